regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth is 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL have port clk  input  1  sole clock; one clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port we  input  1  write enable.
REQ-007 SHALL have port reg_Wt_addr  input  ADDR_W  write address.
REQ-008 SHALL have port wdata  input  DATA_W  write data.
REQ-009 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k occupies slice k.
REQ-010 SHALL have port rdata  output  NUM_RD*DATA_W  packed read data; port k occupies slice k.
REQ-011 SHALL have port rd_pend  output  NUM_RD  pending-write flag of each read address.
REQ-012 SHALL have port pend_set  input  1  marks pend_addr as awaiting a write.
REQ-013 SHALL have port pend_addr  input  ADDR_W  scoreboard set address.
REQ-014 SHALL have port clr_req  input  1  request sequential clear of all registers.
REQ-015 SHALL have port clr_busy  output  1  high while clear sweep runs.

Function
REQ-016 SHALL return 0 on rdata and rd_pend for any port addressing entry 0; entry 0 is never written.
REQ-017 SHALL read combinationally: rdata[k] = entry[rd_addr[k]], rd_pend[k] = pend[rd_addr[k]].
REQ-018 SHALL write wdata to entry reg_Wt_addr at the clock edge when we=1, reg_Wt_addr!=0, clr_busy=0.
REQ-019 SHALL clear the pend bit of reg_Wt_addr on every accepted write.
REQ-020 SHALL set the pend bit of pend_addr at the clock edge when pend_set=1, pend_addr!=0, clr_busy=0.
REQ-021 SHALL give set priority when pend_set and an accepted write target the same address in one cycle: data written, pend ends at 1.
REQ-022 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req=1, with sweep counter loaded to 1.
REQ-023 SHALL in CLEAR zero entry[counter] and pend[counter] each cycle, then increment the counter; after index 2**ADDR_W-1 return to IDLE, total 2**ADDR_W-1 cycles.
REQ-024 SHALL drive clr_busy=1 exactly while in CLEAR, registered.
REQ-025 SHALL ignore we, pend_set and clr_req while clr_busy=1; reads remain valid and show partially cleared contents.

Reset
REQ-026 SHALL on rst=1 at a clock edge zero all entries and pend bits, enter IDLE, clear the counter; clr_busy=0.
REQ-027 SHALL give rst priority over every other input, including mid-sweep, which aborts the sweep.

Configuration
REQ-028 SHALL, with REGFILE_MP_BYPASS_EN defined, forward wdata to rdata[k] and force rd_pend[k]=0 combinationally when an accepted write targets rd_addr[k]!=0 in the same cycle.
REQ-029 SHALL, without REGFILE_MP_BYPASS_EN, return the pre-write value and pend bit until the following cycle.

Structure
REQ-030 SHALL place FSM state typedef (IDLE, CLEAR) and default width constants in shared package regfile_pkg.
REQ-031 SHALL keep the pend scoreboard in sub-module regfile_scoreboard, with set/clear/sweep inputs and per-port flag outputs.

Verification
REQ-032 SHALL cover: write 0xDEADBEEF to r5, next cycle read r5 on port 1 -> 0xDEADBEEF; write to r0 -> r0 reads 0.
REQ-033 SHALL cover: pend_set r7, then rd_pend=1 for r7; write r7 -> rd_pend=0 next cycle; simultaneous set+write r7 -> data updated, rd_pend=1.
REQ-034 SHALL cover: fill r1..r31 with index values, pulse clr_req -> clr_busy high 31 cycles, all read 0 after; we during sweep has no effect.
REQ-035 SHALL cover: rst asserted mid-sweep at counter 10 -> next cycle clr_busy=0, all entries 0.
REQ-036 SHALL cover: same-cycle write r3=0x1234 and read r3 -> 0x1234 with bypass macro, old value without.
REQ-037 SHALL cover: NUM_RD=3, DATA_W=16, ADDR_W=3 instance -> all three ports read independently; sweep lasts 7 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths and
// the states of the sequential clear sweep.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one flag per register, set when a producer is
// issued, cleared when its write lands or the clear sweep passes over it.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic                     sweep_en,
    input  logic [ADDR_W-1:0]        sweep_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_flag
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend;

    // The set is applied after the clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else if (sweep_en) begin
            pend[sweep_addr] <= 1'b0;
        end else begin
            if (clr_en)
                pend[clr_addr] <= 1'b0;
            if (set_en)
                pend[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_flag = '0;
        for (int k = 0; k < NUM_RD; k++)
            rd_flag[k] = pend[rd_addr[k*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired-zero r0, pending-write scoreboard
// and a sequential clear sweep. Define REGFILE_MP_BYPASS_EN for write-to-read forwarding.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        reg_Wt_addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    input  logic                     clr_req,
    output logic                     clr_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    clr_state_t        state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok, set_ok, sweeping;
    logic [NUM_RD-1:0] sb_flag;

    assign sweeping = (state == CLEAR);
    assign clr_busy = sweeping;
    assign wr_ok    = we && (reg_Wt_addr != '0) && !sweeping;
    assign set_ok   = pend_set && (pend_addr != '0) && !sweeping;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Sweep starts at 1 since r0 is constant; it ends after the all-ones index.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                cnt_next = cnt + ADDR_W'(1);
                if (&cnt)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (sweeping) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[reg_Wt_addr] <= wdata;
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (set_ok),
        .set_addr   (pend_addr),
        .clr_en     (wr_ok),
        .clr_addr   (reg_Wt_addr),
        .sweep_en   (sweeping),
        .sweep_addr (cnt),
        .rd_addr    (rd_addr),
        .rd_flag    (sb_flag)
    );

    always_comb begin
        rdata   = '0;
        rd_pend = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_addr[k*ADDR_W +: ADDR_W] != '0) begin
                rdata[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
                rd_pend[k]                = sb_flag[k];
`ifdef REGFILE_MP_BYPASS_EN
                if (wr_ok && (reg_Wt_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
                    rdata[k*DATA_W +: DATA_W] = wdata;
                    rd_pend[k]                = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp: default 2-port instance plus a
// 3-port, 16-bit, 8-entry instance.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  rd_addr;
    logic [63:0] rdata;
    logic [1:0]  rd_pend;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        clr_req;
    logic        clr_busy;

    logic        s_rst;
    logic        s_we;
    logic [2:0]  s_waddr;
    logic [15:0] s_wdata;
    logic [8:0]  s_rd_addr;
    logic [47:0] s_rdata;
    logic [2:0]  s_rd_pend;
    logic        s_pend_set;
    logic [2:0]  s_pend_addr;
    logic        s_clr_req;
    logic        s_clr_busy;

    int n_asserts = 0;
    int n_fail    = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .reg_Wt_addr (waddr),
        .wdata       (wdata),
        .rd_addr     (rd_addr),
        .rdata       (rdata),
        .rd_pend     (rd_pend),
        .pend_set    (pend_set),
        .pend_addr   (pend_addr),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy)
    );

    regfile_mp #(
        .DATA_W (16),
        .ADDR_W (3),
        .NUM_RD (3)
    ) dut3 (
        .clk         (clk),
        .rst         (s_rst),
        .we          (s_we),
        .reg_Wt_addr (s_waddr),
        .wdata       (s_wdata),
        .rd_addr     (s_rd_addr),
        .rdata       (s_rdata),
        .rd_pend     (s_rd_pend),
        .pend_set    (s_pend_set),
        .pend_addr   (s_pend_addr),
        .clr_req     (s_clr_req),
        .clr_busy    (s_clr_busy)
    );

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                                 input logic ps, input logic [4:0] pa, input logic cr);
        we        = w;
        waddr     = a;
        wdata     = d;
        pend_set  = ps;
        pend_addr = pa;
        clr_req   = cr;
    endtask

    task automatic setRead(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        rd_addr = '0;
        s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_rd_addr = '0;
        s_pend_set = 1'b0; s_pend_addr = '0; s_clr_req = 1'b0;
        cycle(2);
        rst = 1'b0;
        s_rst = 1'b0;

        $display("[TB] reset state");
        setRead(5'd5, 5'd31);
        checkOutput("rst_busy", 64'(clr_busy), 64'd0);
        checkOutput("rst_rdata", rdata, 64'd0);
        checkOutput("rst_pend", 64'(rd_pend), 64'd0);

        $display("[TB] basic write/read and r0");
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        cycle(1);
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0);
        setRead(5'd0, 5'd5);
        checkOutput("r5_port1", 64'(rdata[63:32]), 64'hDEADBEEF);
        cycle(1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        setRead(5'd0, 5'd5);
        checkOutput("r0_data", 64'(rdata[31:0]), 64'd0);
        checkOutput("r0_pend", 64'(rd_pend[0]), 64'd0);

        $display("[TB] pending scoreboard");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
        cycle(1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        setRead(5'd7, 5'd5);
        checkOutput("r7_pend_set", 64'(rd_pend), 64'b01);
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 1'b0);
        cycle(1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        setRead(5'd7, 5'd5);
        checkOutput("r7_pend_clr", 64'(rd_pend[0]), 64'd0);
        checkOutput("r7_data", 64'(rdata[31:0]), 64'h77);
        applyStimulus(1'b1, 5'd7, 32'h88, 1'b1, 5'd7, 1'b0);
        cycle(1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        setRead(5'd7, 5'd5);
        checkOutput("r7_setwr_data", 64'(rdata[31:0]), 64'h88);
        checkOutput("r7_setwr_pend", 64'(rd_pend[0]), 64'd1);

        $display("[TB] same-cycle write and read");
        applyStimulus(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 1'b0);
        cycle(1);
        applyStimulus(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 1'b0);
        setRead(5'd3, 5'd0);
`ifdef REGFILE_MP_BYPASS_EN
        checkOutput("r3_same_cycle", 64'(rdata[31:0]), 64'h1234);
        checkOutput("r3_same_pend", 64'(rd_pend[0]), 64'd0);
`else
        checkOutput("r3_same_cycle", 64'(rdata[31:0]), 64'h55);
        checkOutput("r3_same_pend", 64'(rd_pend[0]), 64'd1);
`endif
        cycle(1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        setRead(5'd3, 5'd0);
        checkOutput("r3_after", 64'(rdata[31:0]), 64'h1234);

        $display("[TB] full clear sweep");
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0);
            cycle(1);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
        cycle(1);
        setRead(5'd12, 5'd31);
        checkOutput("fill_r12", 64'(rdata[31:0]), 64'd12);
        checkOutput("fill_r31", 64'(rdata[63:32]), 64'd31);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        cycle(1);
        applyStimulus(1'b1, 5'd2, 32'hBAD, 1'b1, 5'd4, 1'b1);
        setRead(5'd4, 5'd20);
        busy_cnt = 0;
        while (clr_busy && busy_cnt < 64) begin
            busy_cnt++;
            if (busy_cnt == 5) begin
                checkOutput("partial_r4", 64'(rdata[31:0]), 64'd0);
                checkOutput("partial_r20", 64'(rdata[63:32]), 64'd20);
            end
            cycle(1);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("sweep_cycles", 64'(busy_cnt), 64'd31);
        for (int i = 1; i < 32; i++) begin
            setRead(5'(i), 5'd0);
            checkOutput($sformatf("swept_r%0d", i), 64'(rdata[31:0]), 64'd0);
            checkOutput($sformatf("swept_pend_r%0d", i), 64'(rd_pend[0]), 64'd0);
        end
        cycle(2);
        checkOutput("no_restart", 64'(clr_busy), 64'd0);

        $display("[TB] reset during sweep");
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i + 100), 1'b0, 5'd0, 1'b0);
            cycle(1);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b0);
        cycle(1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        cycle(1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        cycle(9);
        setRead(5'd9, 5'd10);
        checkOutput("mid_busy", 64'(clr_busy), 64'd1);
        checkOutput("mid_r9", 64'(rdata[31:0]), 64'd0);
        checkOutput("mid_r10", 64'(rdata[63:32]), 64'd110);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        checkOutput("abort_busy", 64'(clr_busy), 64'd0);
        for (int i = 10; i < 32; i++) begin
            setRead(5'(i), 5'd20);
            checkOutput($sformatf("abort_r%0d", i), 64'(rdata[31:0]), 64'd0);
        end
        checkOutput("abort_pend_r20", 64'(rd_pend), 64'd0);

        $display("[TB] three-port narrow instance");
        s_we = 1'b1; s_waddr = 3'd1; s_wdata = 16'h1111; cycle(1);
        s_waddr = 3'd2; s_wdata = 16'h2222; cycle(1);
        s_waddr = 3'd6; s_wdata = 16'hABCD; cycle(1);
        s_waddr = 3'd7; s_wdata = 16'h7777; cycle(1);
        s_we = 1'b0;
        s_rd_addr = {3'd6, 3'd2, 3'd1};
        #1;
        checkOutput("n3_read_a", 64'(s_rdata), 64'hABCD_2222_1111);
        s_rd_addr = {3'd0, 3'd7, 3'd6};
        #1;
        checkOutput("n3_read_b", 64'(s_rdata), 64'h0000_7777_ABCD);
        s_clr_req = 1'b1;
        cycle(1);
        s_clr_req = 1'b0;
        busy_cnt = 0;
        while (s_clr_busy && busy_cnt < 64) begin
            busy_cnt++;
            cycle(1);
        end
        checkOutput("n3_sweep_cycles", 64'(busy_cnt), 64'd7);
        s_rd_addr = {3'd7, 3'd6, 3'd1};
        #1;
        checkOutput("n3_swept", 64'(s_rdata), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
